// File: rtl/wb_commit.sv
// wb_commit: writeback commit stage with a 32-entry register file, a FIFO release handshake, halt handling and a retire counter.
// Ports:
//   clk, reset (async, active-low)
//   wb_wreg/wb_data/wb_ctrl    : MEM/WB entry; wb_ctrl = {halt, release, reg-write}
//   first_in/last_in           : packet-buffer span captured on a release
//   rd_addr_a/b, rd_data_a/b   : combinational read ports with writeback bypass
//   rel_valid/rel_first/rel_last, rel_ready : release request to the FIFO controller
//   stall                      : freeze upstream when a second release meets a busy controller
//   halted, retire_cnt         : halt status and count of retired entries
module wb_commit #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        wb_wreg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        wb_ctrl,
  input  logic [7:0]        first_in,
  input  logic [7:0]        last_in,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rel_valid,
  output logic [7:0]        rel_first,
  output logic [7:0]        rel_last,
  input  logic              rel_ready,
  output logic              stall,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);
  typedef enum logic [1:0] {IDLE, PEND, HALTED} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] regs [32];
  logic halt_req, halt_req_n;
  logic acc, cap, pend_n, halt_n;
  // halt_req marks a retired halt still waiting for its release handshake;
  // nothing younger than the halt may retire in that window.
  assign stall     = state == PEND && !rel_ready && wb_ctrl[1];
  assign acc       = !stall && state != HALTED && !halt_req;
  assign cap       = acc && wb_ctrl[1];
  assign rel_valid = state == PEND;
  assign halted    = state == HALTED;
  always_comb begin
    pend_n     = cap || (state == PEND && !rel_ready);
    halt_n     = halt_req || (acc && wb_ctrl[2]);
    state_n    = state == HALTED ? HALTED : pend_n ? PEND : halt_n ? HALTED : IDLE;
    halt_req_n = state != HALTED && pend_n && halt_n;
  end
  always_comb begin
    rd_data_a = rd_addr_a == 5'd0 ? '0 :
                (wb_ctrl[0] && wb_wreg == rd_addr_a) ? wb_data : regs[rd_addr_a];
    rd_data_b = rd_addr_b == 5'd0 ? '0 :
                (wb_ctrl[0] && wb_wreg == rd_addr_b) ? wb_data : regs[rd_addr_b];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      halt_req   <= 1'b0;
      rel_first  <= '0;
      rel_last   <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state    <= state_n;
      halt_req <= halt_req_n;
      if (cap) begin
        rel_first <= first_in;
        rel_last  <= last_in;
      end
      if (acc && |wb_ctrl) retire_cnt <= retire_cnt + 1'b1;
      if (acc && wb_ctrl[0] && wb_wreg != 5'd0) regs[wb_wreg] <= wb_data;
    end
  end
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed self-checking bench for wb_commit (CNT_W=4 so the counter wrap is reachable).
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  wb_wreg = '0;
  logic [63:0] wb_data = '0;
  logic [2:0]  wb_ctrl = '0;
  logic [7:0]  first_in = '0, last_in = '0;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic        rel_valid, rel_ready = 1'b0, stall, halted;
  logic [7:0]  rel_first, rel_last;
  logic [3:0]  retire_cnt;
  int tests = 0, fails = 0;
  wb_commit #(.DATA_W(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .wb_wreg(wb_wreg), .wb_data(wb_data), .wb_ctrl(wb_ctrl),
    .first_in(first_in), .last_in(last_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rel_valid(rel_valid),
    .rel_first(rel_first), .rel_last(rel_last), .rel_ready(rel_ready), .stall(stall),
    .halted(halted), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rd_addr_a = 5'd5;
    #12;
    chk("rst_valid", rel_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_reg", rd_data_a, 0);
    chk("rst_first", rel_first, 0);
    reset = 1'b1;
    tick();
    wb_ctrl = 3'b001; wb_wreg = 5'd5; wb_data = 64'hDEAD;
    #1 chk("bypass_a", rd_data_a, 64'hDEAD);
    tick();
    wb_ctrl = 3'b000; wb_data = 64'h0;
    #1 chk("write_a", rd_data_a, 64'hDEAD);
    chk("cnt_write", retire_cnt, 1);
    wb_ctrl = 3'b001; wb_wreg = 5'd0; wb_data = 64'h1234; rd_addr_b = 5'd0;
    #1 chk("r0_bypass", rd_data_b, 0);
    tick();
    wb_ctrl = 3'b000;
    #1 chk("r0_write", rd_data_b, 0);
    chk("cnt_r0", retire_cnt, 2);
    wb_ctrl = 3'b010; first_in = 8'h10; last_in = 8'h3F; rel_ready = 1'b0;
    tick();
    wb_ctrl = 3'b000; first_in = 8'h55; last_in = 8'h66;
    for (int i = 0; i < 3; i++) begin
      chk("rel_valid_hold", rel_valid, 1);
      chk("rel_first_hold", rel_first, 8'h10);
      chk("rel_last_hold", rel_last, 8'h3F);
      if (i < 2) tick();
    end
    rel_ready = 1'b1;
    #1 chk("rel_valid_4th", rel_valid, 1);
    chk("cnt_rel", retire_cnt, 3);
    tick();
    rel_ready = 1'b0;
    chk("rel_done", rel_valid, 0);
    wb_ctrl = 3'b010; first_in = 8'h01; last_in = 8'h02;
    tick();
    chk("b2b_valid", rel_valid, 1);
    chk("b2b_cnt", retire_cnt, 4);
    first_in = 8'h03; last_in = 8'h04;
    #1 chk("b2b_stall", stall, 1);
    tick();
    chk("b2b_cnt_frozen", retire_cnt, 4);
    chk("b2b_first_held", rel_first, 8'h01);
    rel_ready = 1'b1;
    #1 chk("b2b_nostall", stall, 0);
    tick();
    chk("b2b_first_new", rel_first, 8'h03);
    chk("b2b_last_new", rel_last, 8'h04);
    chk("b2b_valid_kept", rel_valid, 1);
    chk("b2b_cnt_acc", retire_cnt, 5);
    wb_ctrl = 3'b000;
    tick();
    chk("b2b_done", rel_valid, 0);
    rel_ready = 1'b0; wb_ctrl = 3'b010; first_in = 8'h77; last_in = 8'h78;
    tick();
    wb_ctrl = 3'b000;
    chk("mid_pend_valid", rel_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", rel_valid, 0);
    chk("mid_rst_reg", rd_data_a, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_cnt", retire_cnt, 0);
    #3 reset = 1'b1;
    tick();
    chk("post_rst_idle", rel_valid, 0);
    wb_ctrl = 3'b001; wb_wreg = 5'd7;
    for (int i = 0; i < 17; i++) begin
      wb_data = 64'(i);
      tick();
    end
    wb_ctrl = 3'b000; rd_addr_a = 5'd7;
    #1 chk("wrap_cnt", retire_cnt, 1);
    chk("wrap_reg", rd_data_a, 16);
    wb_ctrl = 3'b110; first_in = 8'h20; last_in = 8'h21; rel_ready = 1'b0;
    tick();
    wb_ctrl = 3'b000;
    chk("halt_pend_valid", rel_valid, 1);
    chk("halt_pend_halted", halted, 0);
    chk("halt_cnt", retire_cnt, 2);
    rel_ready = 1'b1;
    tick();
    rel_ready = 1'b0;
    chk("halted", halted, 1);
    chk("halt_rel_done", rel_valid, 0);
    wb_ctrl = 3'b011; wb_wreg = 5'd9; wb_data = 64'hBB; rd_addr_b = 5'd9;
    #1 chk("halt_nostall", stall, 0);
    tick();
    wb_ctrl = 3'b000;
    #1 chk("halt_reg_ignored", rd_data_b, 0);
    chk("halt_cnt_frozen", retire_cnt, 2);
    chk("halt_held", halted, 1);
    chk("halt_no_rel", rel_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
